// File: rtl/regfile_scoreboard.sv
// Two-read / two-write register file with same-cycle bypass and a per-register
// load-pending scoreboard that raises a load-use stall. Optional debug port: REGFILE_DEBUG_PORT_EN.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_dst,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              stall,
  output logic [ADDR_W:0]   pending_cnt,
  output logic              waw_err
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic [(1<<ADDR_W)-1:0]   pending_vec
`endif
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int CNT_W    = ADDR_W + 1;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] wb_hit, ld_hit, iss_hit;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                waw_q, waw_d;

  // Per-register write/issue decode; register 0 is never written nor pending when hardwired.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
    localparam logic WRITABLE = !((ZERO_REG != 0) && (gi == 0));
    assign wb_hit[gi]    = WRITABLE && wb_en    && (wb_addr == ADDR_W'(gi));
    assign ld_hit[gi]    = WRITABLE && ld_valid && (ld_addr == ADDR_W'(gi));
    assign iss_hit[gi]   = WRITABLE && ld_issue && (ld_dst  == ADDR_W'(gi));
    // A new issue outranks a same-cycle return: the newer load is still outstanding.
    assign pending_d[gi] = iss_hit[gi] | (pending_q[gi] & ~ld_hit[gi]);
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + CNT_W'(pending_d[i]);
    end
  end

  assign waw_d = waw_q |
                 (wb_en && pending_q[wb_addr] && !(ld_valid && (ld_addr == wb_addr)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
      cnt_q     <= '0;
      waw_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_hit[i]) begin
          regs_q[i] <= wb_data;
        end else if (ld_hit[i]) begin
          regs_q[i] <= ld_data;
        end
      end
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      waw_q     <= waw_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] arr,
    input logic              we_wb,
    input logic [ADDR_W-1:0] a_wb,
    input logic [DATA_W-1:0] d_wb,
    input logic              we_ld,
    input logic [ADDR_W-1:0] a_ld,
    input logic [DATA_W-1:0] d_ld
  );
    if ((ZERO_REG != 0) && (a == '0)) return '0;
    if (we_wb && (a_wb == a))         return d_wb;
    if (we_ld && (a_ld == a))         return d_ld;
    return arr;
  endfunction

  always_comb begin
    rd1_data = read_mux(rs_addr, regs_q[rs_addr], wb_en, wb_addr, wb_data,
                        ld_valid, ld_addr, ld_data);
    rd2_data = read_mux(rt_addr, regs_q[rt_addr], wb_en, wb_addr, wb_data,
                        ld_valid, ld_addr, ld_data);
  end

  logic rtn1, rtn2;
  assign rtn1  = ld_valid && (ld_addr == rs_addr);
  assign rtn2  = ld_valid && (ld_addr == rt_addr);
  assign stall = (rs_used && pending_q[rs_addr] && !rtn1) ||
                 (rt_used && pending_q[rt_addr] && !rtn2);

  assign pending_cnt = cnt_q;
  assign waw_err     = waw_q;

`ifdef REGFILE_DEBUG_PORT_EN
  logic [DATA_W-1:0] dbg_data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dbg_data_q <= '0;
    end else begin
      dbg_data_q <= regs_q[dbg_addr];
    end
  end

  assign dbg_data    = dbg_data_q;
  assign pending_vec = pending_q;
`endif

endmodule
